// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler: arbitrates 16 requesters onto one shared 16:1 mux path and serialises the selected bit.
// Latency: grant/select one edge after request; out/out_valid one further edge behind select.
// Backpressure: none downstream; requesters wait (req held) until the current holder releases or its burst expires.
module mux16_rr_sched #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic [15:0] i,
  output logic [15:0] gnt,
  output logic [3:0]  s,
  output logic        busy,
  output logic        out,
  output logic        out_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Final burst cycle index; the counter is wide enough for MAX_BURST up to 16.
  localparam logic [4:0] BURST_LAST = 5'(MAX_BURST - 1);

  state_t      state_q, state_d;
  logic [15:0] gnt_q, gnt_d;
  logic [3:0]  s_q, s_d;
  logic [3:0]  last_q, last_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        out_q;
  logic        out_valid_q;

  logic        pick_vld;
  logic [3:0]  pick_idx;
  logic        rel;

  // Round-robin search starting just after the last grant; the last holder is examined last.
  always_comb begin
    logic [3:0] idx;
    idx      = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= 16; k++) begin
      idx = last_q + 4'(k);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // Holder gives up the path when it drops its request or exhausts its burst.
  assign rel = (state_q == GRANT) && (!req[s_q] || (cnt_q == BURST_LAST));

  // Next-state and grant bookkeeping; release and re-arbitration happen on the same edge.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          gnt_d   = 16'(1) << pick_idx;
          s_d     = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          if (pick_vld) begin
            gnt_d  = 16'(1) << pick_idx;
            s_d    = pick_idx;
            last_d = pick_idx;
            cnt_d  = '0;
          end else begin
            // Nobody left: drop the grant but keep s so the mux input stays stable.
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      s_q     <= '0;
      last_q  <= 4'd15;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Serial datapath: capture the currently selected bit; hold it while no channel is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_q == GRANT);
      if (state_q == GRANT) begin
        out_q <= i[s_q];
      end
    end
  end

  assign gnt       = gnt_q;
  assign s         = s_q;
  assign busy      = (state_q == GRANT);
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched: one instance with MAX_BURST=4, one with MAX_BURST=1, shared inputs.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// Expected values are hand-derived constants and small index formulas.
module tb_mux16_rr_sched;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] i;

  logic [15:0] gnt4, gnt1;
  logic [3:0]  s4, s1;
  logic        busy4, busy1;
  logic        out4, out1;
  logic        ov4, ov1;

  int n_checks;
  int n_errors;

  mux16_rr_sched #(.MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .i(i),
    .gnt(gnt4), .s(s4), .busy(busy4), .out(out4), .out_valid(ov4)
  );

  mux16_rr_sched #(.MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .i(i),
    .gnt(gnt1), .s(s1), .busy(busy1), .out(out1), .out_valid(ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] iv;
    logic        exp_out;
    logic [15:0] exp_g;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    req = '0;
    i   = '0;
    #2;

    // Reset takes effect without a clock edge.
    rst = 1'b1;
    #1;
    check("rst_gnt", 32'(gnt4), 32'h0);
    check("rst_s", 32'(s4), 32'h0);
    check("rst_busy", 32'(busy4), 32'h0);
    check("rst_out", 32'(out4), 32'h0);
    check("rst_ov", 32'(ov4), 32'h0);
    step();
    rst = 1'b0;

    // Idle with no requests for 10 cycles.
    for (int n = 0; n < 10; n++) begin
      step();
      check("idle_gnt", 32'(gnt4), 32'h0);
      check("idle_s", 32'(s4), 32'h0);
      check("idle_busy", 32'(busy4), 32'h0);
      check("idle_ov", 32'(ov4), 32'h0);
    end

    // Single requester ch5 held: continuous grant, out tracks i[5] one cycle late.
    req = 16'h0020;
    i   = 16'h0000;
    step();
    check("ch5_gnt_first", 32'(gnt4), 32'h0020);
    check("ch5_s_first", 32'(s4), 32'd5);
    check("ch5_busy_first", 32'(busy4), 32'h1);
    check("ch5_ov_first", 32'(ov4), 32'h0);
    iv = 16'h0020;
    i  = iv;
    exp_out = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      check("ch5_gnt", 32'(gnt4), 32'h0020);
      check("ch5_s", 32'(s4), 32'd5);
      check("ch5_busy", 32'(busy4), 32'h1);
      check("ch5_ov", 32'(ov4), 32'h1);
      check("ch5_out", 32'(out4), 32'(exp_out));
      iv = 16'($urandom);
      i  = iv;
      exp_out = iv[5];
    end
    // Request drop: idle, s held, last bit still delivered.
    req = '0;
    step();
    check("ch5_rel_gnt", 32'(gnt4), 32'h0);
    check("ch5_rel_busy", 32'(busy4), 32'h0);
    check("ch5_rel_s", 32'(s4), 32'd5);
    check("ch5_rel_out", 32'(out4), 32'(exp_out));
    check("ch5_rel_ov", 32'(ov4), 32'h1);
    i = ~i;
    step();
    check("ch5_hold_ov", 32'(ov4), 32'h0);
    check("ch5_hold_out", 32'(out4), 32'(exp_out));

    // ch0 and ch15: alternate every 4 cycles back to back across the wrap.
    do_reset();
    req = 16'h8001;
    for (int n = 1; n <= 12; n++) begin
      step();
      exp_g = (((n - 1) / 4) % 2 == 0) ? 16'h0001 : 16'h8000;
      check("wrap_gnt", 32'(gnt4), 32'(exp_g));
      check("wrap_s", 32'(s4), (exp_g == 16'h0001) ? 32'd0 : 32'd15);
      check("wrap_busy", 32'(busy4), 32'h1);
    end

    // ch3 drops at burst cycle 1 while ch9 waits: immediate handover.
    do_reset();
    req = 16'h0008;
    step();
    check("ch3_gnt", 32'(gnt4), 32'h0008);
    req = 16'h0200;
    step();
    check("ch9_gnt", 32'(gnt4), 32'h0200);
    check("ch9_s", 32'(s4), 32'd9);
    // ch3 comes back: ch9 keeps a full fresh burst of 4 before yielding.
    req = 16'h0208;
    for (int n = 0; n < 3; n++) begin
      step();
      check("ch9_burst_gnt", 32'(gnt4), 32'h0200);
    end
    step();
    check("ch3_back_gnt", 32'(gnt4), 32'h0008);
    check("ch3_back_s", 32'(s4), 32'd3);
    check("ch3_back_busy", 32'(busy4), 32'h1);
    req = '0;
    step();
    check("ch3_idle_gnt", 32'(gnt4), 32'h0);
    check("ch3_idle_busy", 32'(busy4), 32'h0);
    check("ch3_idle_s", 32'(s4), 32'd3);

    // All request, MAX_BURST=1: strict rotation, out reproduces i serially.
    do_reset();
    iv  = 16'hA5C3;
    i   = iv;
    req = 16'hFFFF;
    for (int n = 1; n <= 17; n++) begin
      step();
      check("rot_s", 32'(s1), 32'((n - 1) % 16));
      check("rot_gnt", 32'(gnt1), 32'(16'(1) << ((n - 1) % 16)));
      if (n >= 2) begin
        check("rot_ov", 32'(ov1), 32'h1);
        check("rot_out", 32'(out1), 32'(iv[(n - 2) % 16]));
      end
    end

    // Reset mid-burst on ch7 aborts at once; next search starts at ch0.
    do_reset();
    i   = 16'hFFFF;
    req = 16'h0080;
    step();
    check("ch7_gnt", 32'(gnt4), 32'h0080);
    step();
    step();
    check("ch7_out_pre", 32'(out4), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(gnt4), 32'h0);
    check("mid_rst_s", 32'(s4), 32'h0);
    check("mid_rst_busy", 32'(busy4), 32'h0);
    check("mid_rst_out", 32'(out4), 32'h0);
    check("mid_rst_ov", 32'(ov4), 32'h0);
    step();
    rst = 1'b0;
    req = 16'hFFFF;
    step();
    check("post_rst_gnt", 32'(gnt4), 32'h0001);
    check("post_rst_s", 32'(s4), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux16_rr_sched.md
Name: mux16_rr_sched

Overview:
- Round-robin scheduler that shares a 16-input, 1-bit mux path among 16 requesters.
- Arbitrates req[15:0], drives the 4-bit select, and registers the selected data bit into a serial output stream with a valid flag.
- Sits in front of the 16:1 mux structure. It is the only block that drives its select lines.

Parameters:
- MAX_BURST, default 4, maximum consecutive cycles one requester may hold the grant. Legal range 1..16.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  request lines; req[k] high means channel k wants the path.
- i  input  16  data bits; i[k] belongs to channel k.
- gnt  output  16  one-hot grant, registered; all zero when idle.
- s  output  4  mux select, registered; equals index of the granted channel.
- busy  output  1  high while in GRANT state.
- out  output  1  registered selected data bit.
- out_valid  output  1  high when out carries a granted channel's bit.

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, s=0, busy=0, out=0, out_valid=0, burst counter=0, last-granted pointer=15 (first search starts at channel 0). Outputs take these values immediately, not at the next edge.
- Search order: from (last+1) mod 16 upward, wrapping through 15->0. The current/last channel is checked last, so it wins only if no other channel requests.
- State IDLE:
  - If req != 0 at a clock edge: grant the first requester in search order. Set gnt=one-hot(k), s=k, last=k, cnt=0, state=GRANT.
  - Latency: req high before edge N gives gnt visible after edge N (one cycle).
- State GRANT (channel c), at each edge:
  - Release when req[c]=0, or when cnt==MAX_BURST-1.
  - On release with other req bits set: re-arbitrate in the same edge, with no idle bubble. New grant, cnt=0.
  - On release with req==0 (or only req[c] set after a req[c] drop): go to IDLE; gnt=0, busy=0. s holds its last value.
  - On release with only req[c] set after burst expiry: c is re-granted, cnt=0. It is the sole requester.
  - No release: cnt increments; gnt and s unchanged.
- Requests that rise while another channel holds the grant wait for the next release. Request rise/fall mid-burst for non-granted channels has no effect.
- Datapath: each edge, out <= i[s_current] and out_valid <= busy_current. out therefore lags s by one cycle. out_valid=0 keeps out at its previous value.
- Counter is 5 bits internally. MAX_BURST=1 gives strict per-cycle rotation among active requesters.
- Reset asserted mid-burst aborts immediately. After release, arbitration restarts from channel 0.
- gnt is always one-hot or zero, never multi-hot.

Test Plan:
- Reset then req=16'h0000 for 10 cycles -> gnt=0, s=0, busy=0, out_valid=0 throughout.
- Single requester req=16'h0020 held high, MAX_BURST=4 -> gnt=16'h0020, s=5 after one edge and held continuously (re-grant every 4 cycles). out follows i[5] with one-cycle lag.
- req=16'h8001 held, MAX_BURST=4 -> grants alternate: ch0 for 4 cycles, ch15 for 4 cycles, ch0 again. Switches are back-to-back with busy never dropping, which exercises the wrap-around at 15->0.
- ch3 granted, req[3] dropped at burst cycle 1 with req[9]=1 -> next edge gnt=16'h0200, s=9, cnt restarts. If req=0 instead -> IDLE, gnt=0.
- All 16 requesting, MAX_BURST=1 -> s sequence 0,1,2,...,15,0 one per cycle. out reproduces i[0..15] serially one cycle later with out_valid=1.
- rst pulsed mid-burst on ch7 -> outputs zero immediately. After release with req=16'hFFFF, the first grant is ch0, not ch8.
